// File: rtl/mem_arb_pkg.sv
// Shared types and port identifiers for the data-memory arbiter.
package mem_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    LOCK1 = 1'b1
  } arb_state_t;

  typedef logic port_id_t;

  localparam port_id_t PORT_CPU = 1'b0;
  localparam port_id_t PORT_DBG = 1'b1;

endpackage

// File: rtl/dmem_arbiter_if.sv
// Request/grant/response bundle between two requesters, the arbiter and data memory.
// slave = arbiter side; master = requesters plus memory side.
interface dmem_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic            m0_req,   m1_req;
  logic            m0_we,    m1_we;
  logic [AW-1:0]   m0_addr,  m1_addr;
  logic [DW-1:0]   m0_wdata, m1_wdata;
  logic [DW/8-1:0] m0_be,    m1_be;
  logic            m1_lock;
  logic            m0_gnt,   m1_gnt;
  logic            m0_rvalid, m1_rvalid;
  logic [DW-1:0]   m0_rdata, m1_rdata;
  logic            mem_en,   mem_we;
  logic [AW-1:0]   mem_addr;
  logic [DW-1:0]   mem_wdata;
  logic [DW/8-1:0] mem_be;
  logic [DW-1:0]   mem_rdata;

  modport slave (
    input  m0_req, m1_req, m0_we, m1_we, m0_addr, m1_addr,
           m0_wdata, m1_wdata, m0_be, m1_be, m1_lock, mem_rdata,
    output m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, m0_rdata, m1_rdata,
           mem_en, mem_we, mem_addr, mem_wdata, mem_be
  );

  modport master (
    output m0_req, m1_req, m0_we, m1_we, m0_addr, m1_addr,
           m0_wdata, m1_wdata, m0_be, m1_be, m1_lock, mem_rdata,
    input  m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, m0_rdata, m1_rdata,
           mem_en, mem_we, mem_addr, mem_wdata, mem_be
  );

endinterface

// File: rtl/mem_arb_pick.sv
// Combinational winner select for the two-port arbiter.
// MEM_ARB_RR_EN selects round-robin ties (uses last_gnt); otherwise port 0 wins ties.
module mem_arb_pick
  import mem_arb_pkg::*;
(
  input  logic       m0_req,
  input  logic       m1_req,
  input  logic       m1_lock,
  input  arb_state_t state,
  input  logic       lock_exp,
`ifdef MEM_ARB_RR_EN
  input  port_id_t   last_gnt,
`endif
  output logic       gnt0,
  output logic       gnt1
);

  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    // A dropped lock falls through to normal arbitration in the same cycle.
    if (state == LOCK1 && m1_lock) begin
      if (lock_exp && m0_req) begin
        gnt0 = 1'b1;
      end else if (m1_req) begin
        gnt1 = 1'b1;
      end else if (m0_req) begin
        gnt0 = 1'b1;
      end
    end else if (m0_req && m1_req) begin
`ifdef MEM_ARB_RR_EN
      if (last_gnt == PORT_CPU) begin
        gnt1 = 1'b1;
      end else begin
        gnt0 = 1'b1;
      end
`else
      gnt0 = 1'b1;
`endif
    end else begin
      gnt0 = m0_req;
      gnt1 = m1_req;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port data-memory arbiter (CPU port 0, debug/loader port 1) with bounded port-1 lock.
// Build option: MEM_ARB_RR_EN enables round-robin tie breaking.
module dmem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int AW       = 32,
  parameter int DW       = 32,
  parameter int LOCK_MAX = 16
) (
  input logic           clk,
  input logic           reset,
  dmem_arbiter_if.slave bus
);

  localparam int CW = $clog2(LOCK_MAX + 1);

  arb_state_t    state_q, state_d;
  logic [CW-1:0] lock_cnt_q, lock_cnt_d;
  logic          lock_exp;
  logic          req0, req1;
  logic          gnt0, gnt1, gnt_any;
  logic          rd_pend_p1;
  port_id_t      rd_owner_p1;
  logic [DW-1:0] rdata0_q, rdata1_q;
  logic          rv0, rv1;

  // Reset masks requests so no access issues while reset is held.
  assign req0     = bus.m0_req & ~reset;
  assign req1     = bus.m1_req & ~reset;
  assign lock_exp = (lock_cnt_q == CW'(LOCK_MAX));
  assign gnt_any  = gnt0 | gnt1;

`ifdef MEM_ARB_RR_EN
  port_id_t last_gnt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      last_gnt_q <= PORT_DBG;
    end else if (gnt0) begin
      last_gnt_q <= PORT_CPU;
    end else if (gnt1) begin
      last_gnt_q <= PORT_DBG;
    end
  end
`endif

  mem_arb_pick u_pick (
    .m0_req   (req0),
    .m1_req   (req1),
    .m1_lock  (bus.m1_lock),
    .state    (state_q),
    .lock_exp (lock_exp),
`ifdef MEM_ARB_RR_EN
    .last_gnt (last_gnt_q),
`endif
    .gnt0     (gnt0),
    .gnt1     (gnt1)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      lock_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      lock_cnt_q <= lock_cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    lock_cnt_d = lock_cnt_q;
    case (state_q)
      IDLE: begin
        if (gnt1 && bus.m1_lock) begin
          state_d    = LOCK1;
          lock_cnt_d = '0;
        end
      end
      LOCK1: begin
        if (!bus.m1_lock) begin
          state_d    = IDLE;
          lock_cnt_d = '0;
        end else if (gnt0 && lock_exp) begin
          lock_cnt_d = '0;
        end else if (gnt1 && bus.m0_req) begin
          lock_cnt_d = lock_cnt_q + CW'(1);
        end
      end
      default: begin
        state_d    = IDLE;
        lock_cnt_d = '0;
      end
    endcase
  end

  always_comb begin
    bus.mem_en    = gnt_any;
    bus.mem_we    = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    bus.mem_be    = '0;
    if (gnt0) begin
      bus.mem_we    = bus.m0_we;
      bus.mem_addr  = bus.m0_addr;
      bus.mem_wdata = bus.m0_wdata;
      bus.mem_be    = bus.m0_be;
    end else if (gnt1) begin
      bus.mem_we    = bus.m1_we;
      bus.mem_addr  = bus.m1_addr;
      bus.mem_wdata = bus.m1_wdata;
      bus.mem_be    = bus.m1_be;
    end
  end

  // Stage p0 -> p1: grant cycle to read-response cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_pend_p1  <= 1'b0;
      rd_owner_p1 <= PORT_CPU;
      rdata0_q    <= '0;
      rdata1_q    <= '0;
    end else begin
      rd_pend_p1  <= gnt_any & ~bus.mem_we;
      rd_owner_p1 <= gnt1 ? PORT_DBG : PORT_CPU;
      if (rv0) begin
        rdata0_q <= bus.mem_rdata;
      end
      if (rv1) begin
        rdata1_q <= bus.mem_rdata;
      end
    end
  end

  // Memory data arrives in the response cycle; it is forwarded then and held afterwards.
  assign rv0 = rd_pend_p1 & ~reset & (rd_owner_p1 == PORT_CPU);
  assign rv1 = rd_pend_p1 & ~reset & (rd_owner_p1 == PORT_DBG);

  assign bus.m0_gnt    = gnt0;
  assign bus.m1_gnt    = gnt1;
  assign bus.m0_rvalid = rv0;
  assign bus.m1_rvalid = rv1;
  assign bus.m0_rdata  = reset ? '0 : (rv0 ? bus.mem_rdata : rdata0_q);
  assign bus.m1_rdata  = reset ? '0 : (rv1 ? bus.mem_rdata : rdata1_q);

endmodule

// File: tb/tb_dmem_arbiter.sv
// Testbench for dmem_arbiter: directed scenarios followed by randomized traffic,
// all checked each cycle against a behavioural model of the arbitration rules.
module tb_dmem_arbiter;

  localparam int LM = 4;

  logic clk = 1'b0;
  logic reset;
  logic preload;

  dmem_arbiter_if #(.AW(32), .DW(32)) bus ();

  dmem_arbiter #(.AW(32), .DW(32), .LOCK_MAX(LM)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] init_word(input int i);
    if (i == 4) return 32'hDEADBEEF;
    return 32'hA5000000 ^ (32'(i) * 32'h01010101);
  endfunction

  // Synchronous data memory seen by the arbiter.
  logic [31:0] tbmem [64];
  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 64; i++) tbmem[i] <= init_word(i);
    end else if (bus.mem_en) begin
      if (bus.mem_we) begin
        for (int b = 0; b < 4; b++)
          if (bus.mem_be[b]) tbmem[bus.mem_addr[7:2]][8*b +: 8] <= bus.mem_wdata[8*b +: 8];
      end else begin
        bus.mem_rdata <= tbmem[bus.mem_addr[7:2]];
      end
    end
  end

  int checks = 0;
  int errors = 0;

  // Reference model state.
  logic [31:0] ref_mem [64];
  bit          m_locked;
  int          m_streak;
  int          m_last;
  bit          m_pend;
  int          m_owner;
  logic [31:0] m_resp, m_held0, m_held1;
  int          exp_w;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int pick_w();
    if (reset) return -1;
    if (m_locked && bus.m1_lock) begin
      if (bus.m0_req && m_streak >= LM) return 0;
      if (bus.m1_req) return 1;
      if (bus.m0_req) return 0;
      return -1;
    end
    if (bus.m0_req && bus.m1_req) begin
`ifdef MEM_ARB_RR_EN
      return (m_last == 0) ? 1 : 0;
`else
      return 0;
`endif
    end
    if (bus.m0_req) return 0;
    if (bus.m1_req) return 1;
    return -1;
  endfunction

  task automatic check_all();
    logic [31:0] ea, ed, er0, er1;
    logic [3:0]  eb;
    logic        ew, rv0, rv1;
    exp_w = pick_w();
    ew = 1'b0; ea = '0; ed = '0; eb = '0;
    if (exp_w == 0) begin
      ew = bus.m0_we; ea = bus.m0_addr; ed = bus.m0_wdata; eb = bus.m0_be;
    end else if (exp_w == 1) begin
      ew = bus.m1_we; ea = bus.m1_addr; ed = bus.m1_wdata; eb = bus.m1_be;
    end
    rv0 = !reset && m_pend && m_owner == 0;
    rv1 = !reset && m_pend && m_owner == 1;
    er0 = reset ? 32'h0 : (rv0 ? m_resp : m_held0);
    er1 = reset ? 32'h0 : (rv1 ? m_resp : m_held1);
    chk("m0_gnt",    bus.m0_gnt,    exp_w == 0);
    chk("m1_gnt",    bus.m1_gnt,    exp_w == 1);
    chk("mem_en",    bus.mem_en,    exp_w >= 0);
    chk("mem_we",    bus.mem_we,    ew);
    chk("mem_addr",  bus.mem_addr,  ea);
    chk("mem_wdata", bus.mem_wdata, ed);
    chk("mem_be",    bus.mem_be,    eb);
    chk("m0_rvalid", bus.m0_rvalid, rv0);
    chk("m1_rvalid", bus.m1_rvalid, rv1);
    chk("m0_rdata",  bus.m0_rdata,  er0);
    chk("m1_rdata",  bus.m1_rdata,  er1);
  endtask

  task automatic model_update();
    logic        we;
    logic [31:0] a, d;
    logic [3:0]  be;
    if (reset) begin
      m_locked = 0; m_streak = 0; m_last = 1; m_pend = 0; m_owner = 0;
      m_held0 = '0; m_held1 = '0;
    end else begin
      if (m_pend) begin
        if (m_owner == 0) m_held0 = m_resp; else m_held1 = m_resp;
      end
      if (m_locked && bus.m1_lock) begin
        if (exp_w == 0 && m_streak >= LM) m_streak = 0;
        else if (exp_w == 1 && bus.m0_req) m_streak++;
      end else begin
        m_locked = (exp_w == 1 && bus.m1_lock);
        m_streak = 0;
      end
      if (exp_w >= 0) m_last = exp_w;
      m_pend = 0;
      if (exp_w >= 0) begin
        we = (exp_w == 0) ? bus.m0_we    : bus.m1_we;
        a  = (exp_w == 0) ? bus.m0_addr  : bus.m1_addr;
        d  = (exp_w == 0) ? bus.m0_wdata : bus.m1_wdata;
        be = (exp_w == 0) ? bus.m0_be    : bus.m1_be;
        if (we) begin
          for (int b = 0; b < 4; b++)
            if (be[b]) ref_mem[a[7:2]][8*b +: 8] = d[8*b +: 8];
        end else begin
          m_pend  = 1;
          m_owner = exp_w;
          m_resp  = ref_mem[a[7:2]];
        end
      end
    end
  endtask

  task automatic cyc();
    @(negedge clk);
    check_all();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic set_m0(input logic req, input logic we, input logic [31:0] a,
                        input logic [31:0] d, input logic [3:0] be);
    bus.m0_req = req; bus.m0_we = we; bus.m0_addr = a; bus.m0_wdata = d; bus.m0_be = be;
  endtask

  task automatic set_m1(input logic req, input logic we, input logic [31:0] a,
                        input logic [31:0] d, input logic [3:0] be, input logic lk);
    bus.m1_req = req; bus.m1_we = we; bus.m1_addr = a; bus.m1_wdata = d; bus.m1_be = be;
    bus.m1_lock = lk;
  endtask

  initial begin
    for (int i = 0; i < 64; i++) ref_mem[i] = init_word(i);
    m_locked = 0; m_streak = 0; m_last = 1; m_pend = 0; m_owner = 0;
    m_resp = '0; m_held0 = '0; m_held1 = '0; exp_w = -1;
    reset = 1'b1;
    preload = 1'b1;
    set_m0(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    set_m1(1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0);
    cyc();
    preload = 1'b0;

    // Reset state, with a request present that must not be granted.
    set_m0(1'b1, 1'b0, 32'h10, 32'h0, 4'hF);
    #1;
    chk("rst_m0_gnt", bus.m0_gnt, 1'b0);
    chk("rst_mem_en", bus.mem_en, 1'b0);
    chk("rst_rvalid", {bus.m0_rvalid, bus.m1_rvalid}, 2'b00);
    chk("rst_rdata", {bus.m0_rdata, bus.m1_rdata}, 64'h0);
    cyc();
    reset = 1'b0;

    // Single m0 read of 0x10.
    #1;
    chk("t1_m0_gnt", bus.m0_gnt, 1'b1);
    cyc();
    bus.m0_req = 1'b0;
    #1;
    chk("t1_m0_rvalid", bus.m0_rvalid, 1'b1);
    chk("t1_m0_rdata", bus.m0_rdata, 32'hDEADBEEF);
    chk("t1_m1_rvalid", bus.m1_rvalid, 1'b0);
    cyc();

    // Both ports read every cycle from a fresh reset.
    reset = 1'b1;
    set_m0(1'b1, 1'b0, 32'h0, 32'h0, 4'hF);
    set_m1(1'b1, 1'b0, 32'h4, 32'h0, 4'hF, 1'b0);
    cyc();
    reset = 1'b0;
    for (int k = 0; k < 4; k++) begin
      logic e1;
`ifdef MEM_ARB_RR_EN
      e1 = (k % 2 == 1);
`else
      e1 = 1'b0;
`endif
      #1;
      chk("t2_m0_gnt", bus.m0_gnt, !e1);
      chk("t2_m1_gnt", bus.m1_gnt, e1);
      cyc();
    end
    bus.m0_req = 1'b0; bus.m1_req = 1'b0;
    cyc();

    // Byte write from m1 then read back from m0.
    set_m1(1'b1, 1'b1, 32'h20, 32'h00000055, 4'b0001, 1'b0);
    #1;
    chk("t3_m1_gnt", bus.m1_gnt, 1'b1);
    chk("t3_mem_be", bus.mem_be, 4'b0001);
    cyc();
    bus.m1_req = 1'b0;
    set_m0(1'b1, 1'b0, 32'h20, 32'h0, 4'hF);
    cyc();
    bus.m0_req = 1'b0;
    #1;
    chk("t3_m0_rvalid", bus.m0_rvalid, 1'b1);
    chk("t3_byte0", bus.m0_rdata[7:0], 8'h55);
    cyc();

    // Locked burst from m1 while m0 waits.
    set_m1(1'b1, 1'b0, 32'h30, 32'h0, 4'hF, 1'b1);
    #1;
    chk("t4_enter_gnt", bus.m1_gnt, 1'b1);
    cyc();
    set_m0(1'b1, 1'b0, 32'h34, 32'h0, 4'hF);
    for (int k = 0; k < LM; k++) begin
      #1;
      chk("t4_lock_m1_gnt", bus.m1_gnt, 1'b1);
      chk("t4_lock_m0_gnt", bus.m0_gnt, 1'b0);
      cyc();
    end
    #1;
    chk("t4_expire_m0_gnt", bus.m0_gnt, 1'b1);
    chk("t4_expire_m1_gnt", bus.m1_gnt, 1'b0);
    cyc();
    #1;
    chk("t4_after_m1_gnt", bus.m1_gnt, 1'b1);
    cyc();

    // Lock released with both requesting: tie policy in the same cycle.
    bus.m1_lock = 1'b0;
    #1;
    chk("t6_release_m0_gnt", bus.m0_gnt, 1'b1);
    cyc();
    #1;
`ifdef MEM_ARB_RR_EN
    chk("t6_next_m1_gnt", bus.m1_gnt, 1'b1);
`else
    chk("t6_next_m0_gnt", bus.m0_gnt, 1'b1);
`endif
    cyc();
    bus.m0_req = 1'b0; bus.m1_req = 1'b0;
    cyc();

    // Reset while a read is in flight and the lock is held.
    set_m1(1'b1, 1'b1, 32'h3C, 32'h12345678, 4'hF, 1'b1);
    cyc();
    bus.m1_req = 1'b0;
    set_m0(1'b1, 1'b0, 32'h10, 32'h0, 4'hF);
    #1;
    chk("t5_m0_gnt", bus.m0_gnt, 1'b1);
    cyc();
    reset = 1'b1;
    bus.m0_req = 1'b0;
    #1;
    chk("t5_rst_rvalid", bus.m0_rvalid, 1'b0);
    chk("t5_rst_rdata", bus.m0_rdata, 32'h0);
    chk("t5_rst_mem_en", bus.mem_en, 1'b0);
    cyc();
    reset = 1'b0;
    bus.m0_req = 1'b1;
    set_m1(1'b1, 1'b0, 32'h8, 32'h0, 4'hF, 1'b1);
    #1;
    chk("t5_after_rvalid", bus.m0_rvalid, 1'b0);
    chk("t5_idle_tie_m0", bus.m0_gnt, 1'b1);
    cyc();
    bus.m0_req = 1'b0;
    cyc();
    bus.m1_req = 1'b0; bus.m1_lock = 1'b0;
    cyc();

    // Randomized traffic; requests held until the model says they were granted.
    for (int n = 0; n < 400; n++) begin
      if (!bus.m0_req && $urandom_range(0, 2) == 0)
        set_m0(1'b1, 1'($urandom_range(0, 1)), 32'($urandom_range(0, 63)) << 2,
               $urandom(), 4'($urandom_range(0, 15)));
      if (!bus.m1_req && $urandom_range(0, 2) == 0)
        set_m1(1'b1, 1'($urandom_range(0, 1)), 32'($urandom_range(0, 63)) << 2,
               $urandom(), 4'($urandom_range(0, 15)), bus.m1_lock);
      if ($urandom_range(0, 7) == 0) bus.m1_lock = ~bus.m1_lock;
      reset = ($urandom_range(0, 99) == 0);
      cyc();
      if (exp_w == 0) bus.m0_req = 1'b0;
      else if (exp_w == 1) bus.m1_req = 1'b0;
    end
    reset = 1'b0;
    bus.m0_req = 1'b0; bus.m1_req = 1'b0; bus.m1_lock = 1'b0;
    cyc();
    cyc();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-port arbiter that shares the single-cycle CPU's data memory between the CPU load/store port (port 0) and a debug/program-loader port (port 1). Sits between the CPU datapath and data memory. Issues at most one memory access per cycle and returns read data one cycle later, tagged to the owner. Supports a bounded lock so the loader can stream bursts without starving the CPU.

## Interface
Parameters:
- AW, 32, address width
- DW, 32, data width (byte enables are DW/8)
- LOCK_MAX, 16, maximum consecutive locked port-1 grants while port 0 is waiting

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  synchronous, active-high
- m0_req, m1_req  in  1  access request; held with its payload until granted
- m0_we, m1_we  in  1  1 = write, 0 = read
- m0_addr, m1_addr  in  AW  byte address
- m0_wdata, m1_wdata  in  DW  write data
- m0_be, m1_be  in  DW/8  byte enables
- m1_lock  in  1  loader requests that port 1 keep ownership
- m0_gnt, m1_gnt  out  1  combinational grant; the access issues this cycle
- m0_rvalid, m1_rvalid  out  1  read data valid for that port (registered)
- m0_rdata, m1_rdata  out  DW  read data, registered
- mem_en, mem_we  out  1  memory access strobe and write enable
- mem_addr  out  AW;  mem_wdata  out  DW;  mem_be  out  DW/8
- mem_rdata  in  DW  memory read data, valid the cycle after mem_en with mem_we = 0

## Operation
- At most one gnt per cycle. mem_* are muxed combinationally from the granted port. With no grant, mem_en = 0 and the other mem_* outputs are 0.
- Arbitration uses the state machine below (IDLE/LOCK1), plus the last_gnt pointer (see Configuration).
- IDLE:
  - Single requester is granted.
  - Both requesting: the configured policy picks the winner.
  - If port 1 is granted with m1_lock = 1, go to LOCK1 and clear lock_cnt.
- LOCK1:
  - Only port 1 is granted. lock_cnt increments on each port-1 grant made while m0_req = 1.
  - If lock_cnt reaches LOCK_MAX with m0_req = 1, port 0 gets exactly one grant that cycle. lock_cnt clears and the block stays in LOCK1.
  - If m1_lock = 0, return to IDLE. Normal arbitration applies in that same cycle.
  - If m1_req = 0 in LOCK1, port 0 may be granted; the lock is held until m1_lock drops.
- Read response:
  - A granted read sets rd_pend and records rd_owner.
  - Next cycle: the owner's rvalid = 1 and its rdata = mem_rdata, captured into the rdata register.
  - The non-owner's rvalid = 0; its rdata holds its last value.
- Writes produce no response.
- Back-to-back reads from either port are fully pipelined, one per cycle.
- Reset:
  - gnt, mem_en, rvalid and rdata are all 0; state = IDLE; lock_cnt = 0; last_gnt = 1, so port 0 wins the first tie.
  - Reset mid-read drops the pending response; no rvalid follows.

## Timing
- Grant latency: 0 cycles. gnt is asserted in the cycle req is sampled, if that port wins.
- Write commits at the rising edge that ends the grant cycle.
- Read latency: rvalid 1 cycle after gnt, for exactly 1 cycle per granted read.
- The loser's wait is bounded:
  - round-robin: 1 cycle (lock off)
  - locked: LOCK_MAX + 1 cycles
  - fixed priority: port 1 is unbounded while port 0 requests continuously
- Requesters must keep req and payload stable until gnt. The arbiter does not register requests.

## Configuration
- MEM_ARB_RR_EN defined:
  - Round-robin on ties in IDLE. The port not granted last wins.
  - last_gnt updates on every grant.
- Undefined:
  - Fixed priority: port 0 always wins ties in IDLE.
  - last_gnt is not implemented.
  - The lock and LOCK_MAX behaviour are unchanged.

## Structure
- Shared package mem_arb_pkg holds:
  - typedef enum arb_state_t {IDLE, LOCK1}
  - typedef port_id_t (1 bit)
  - constants PORT_CPU = 0, PORT_DBG = 1
- One natural sub-module, mem_arb_pick: a combinational winner select from req, state, last_gnt and the lock_cnt expiry. The FSM, counter and response registers stay in dmem_arbiter.

## Test plan
- Reset, then m0 read of addr 0x10 with memory word 0xDEADBEEF → m0_gnt in the same cycle; m0_rvalid = 1 and m0_rdata = 0xDEADBEEF next cycle; m1_rvalid = 0.
- Both ports request reads every cycle, 4 cycles, lock off:
  - with MEM_ARB_RR_EN: grants alternate 0,1,0,1
  - without it: 0,0,0,0
- m1 write 0x00000055 with be = 4'b0001 to 0x20, then m0 read of 0x20 one cycle later → m0_rdata byte 0 = 0x55.
- m1_lock = 1 and m1_req held, m0_req held, LOCK_MAX = 4 → m1 granted 4 cycles, m0 granted in the 5th, m1 granted again after that.
- m0 read granted, reset asserted the next cycle → m0_rvalid stays 0; all outputs 0; state IDLE.
- Lock released: m1_lock drops while both ports request → normal tie policy applies in that same cycle.
